cpu_clk_phase: RTL and testbench

CPU_CLK_PHASE -- requirements
Module: cpu_clk_phase

---
 rtl/cpu_clk_phase.sv | 138 +++++++++++++
 tb/tb_cpu_clk_phase.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_phase.sv
// rtl/cpu_clk_phase.sv - T-state/M-cycle sequencer driven by a sampled CPU clock
// Optional edge watchdog: define CLK_PHASE_WDOG_EN.
module cpu_clk_phase #(
  parameter int MAX_GAP = 32,
  parameter int M_CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_clk_in,
  input  logic               halt_req,
  input  logic               wake,
  output logic               t_rise,
  output logic               t_fall,
  output logic [1:0]         t_phase,
  output logic               m_en,
  output logic [M_CNT_W-1:0] m_count,
  output logic               halted,
  output logic               clk_err
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_PEND = 2'd1,
    HALTED    = 2'd2
  } state_e;

  state_e               state_q;
  logic                 cpu_clk_d;
  logic                 t_rise_q;
  logic                 t_fall_q;
  logic [1:0]           t_phase_q;
  logic                 m_en_q;
  logic [M_CNT_W-1:0]   m_count_q;
  logic                 halted_q;

  logic rise;
  logic fall;
  logic advance;
  logic wrap;

  assign rise    = cpu_clk_in & ~cpu_clk_d;
  assign fall    = ~cpu_clk_in & cpu_clk_d;
  assign advance = rise && (state_q != HALTED);
  assign wrap    = (t_phase_q == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      cpu_clk_d <= 1'b0;
      t_rise_q  <= 1'b0;
      t_fall_q  <= 1'b0;
      t_phase_q <= 2'd0;
      m_en_q    <= 1'b0;
      m_count_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      cpu_clk_d <= cpu_clk_in;
      t_rise_q  <= rise;
      t_fall_q  <= fall;
      m_en_q    <= 1'b0;

      if (advance) begin
        t_phase_q <= t_phase_q + 2'd1;
        if (wrap) begin
          m_en_q    <= 1'b1;
          m_count_q <= m_count_q + M_CNT_W'(1);
        end
      end

      // wake always wins over halt_req, so a simultaneous pair never halts
      case (state_q)
        RUN: begin
          if (halt_req && !wake) begin
            state_q <= HALT_PEND;
          end
        end
        HALT_PEND: begin
          if (wake) begin
            state_q <= RUN;
          end else if (rise && wrap) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end
        end
        HALTED: begin
          if (wake) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign t_rise  = t_rise_q;
  assign t_fall  = t_fall_q;
  assign t_phase = t_phase_q;
  assign m_en    = m_en_q;
  assign m_count = m_count_q;
  assign halted  = halted_q;

`ifdef CLK_PHASE_WDOG_EN
  localparam int GAP_W = $clog2(MAX_GAP + 1);

  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_d;
  logic             clk_err_q;

  always_comb begin
    gap_d = gap_q;
    if (rise || fall) begin
      gap_d = '0;
    end else if (gap_q != GAP_W'(MAX_GAP)) begin
      gap_d = gap_q + GAP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_q     <= '0;
      clk_err_q <= 1'b0;
    end else begin
      gap_q     <= gap_d;
      clk_err_q <= clk_err_q | (gap_d == GAP_W'(MAX_GAP));
    end
  end

  assign clk_err = clk_err_q;
`else
  // MAX_GAP only matters with the watchdog built in
  assign clk_err = 1'b0 & (MAX_GAP == 0);
`endif

endmodule

// File: tb/tb_cpu_clk_phase.sv
// tb/tb_cpu_clk_phase.sv - directed self-checking bench for cpu_clk_phase
module tb_cpu_clk_phase;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_clk_in;
  logic       halt_req;
  logic       wake;
  logic       t_rise;
  logic       t_fall;
  logic [1:0] t_phase;
  logic       m_en;
  logic [3:0] m_count;
  logic       halted;
  logic       clk_err;

  int n_checks = 0;
  int n_fail   = 0;

  int rise_cnt = 0, fall_cnt = 0, men_cnt = 0, halted_cnt = 0, width_err = 0;
  logic prev_rise = 1'b0, prev_fall = 1'b0;

  logic [1:0] last_phase;
  logic       last_m_en;

  int s_rise, s_fall, s_men, s_halt;

`ifdef CLK_PHASE_WDOG_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  cpu_clk_phase #(.MAX_GAP(32), .M_CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_clk_in (cpu_clk_in),
    .halt_req   (halt_req),
    .wake       (wake),
    .t_rise     (t_rise),
    .t_fall     (t_fall),
    .t_phase    (t_phase),
    .m_en       (m_en),
    .m_count    (m_count),
    .halted     (halted),
    .clk_err    (clk_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (t_rise) rise_cnt++;
    if (t_fall) fall_cnt++;
    if (m_en)   men_cnt++;
    if (halted) halted_cnt++;
    if ((t_rise && prev_rise) || (t_fall && prev_fall)) width_err++;
    prev_rise = t_rise;
    prev_fall = t_fall;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // one cpu_clk_in period; captures outputs right after the rise is registered
  task automatic rise_cycle(input int hi, input int lo);
    cpu_clk_in = 1'b1;
    tick(1);
    last_phase = t_phase;
    last_m_en  = m_en;
    tick(hi - 1);
    cpu_clk_in = 1'b0;
    tick(lo);
  endtask

  task automatic snap();
    s_rise = rise_cnt;
    s_fall = fall_cnt;
    s_men  = men_cnt;
    s_halt = halted_cnt;
  endtask

  initial begin
    rst = 1'b1; cpu_clk_in = 1'b0; halt_req = 1'b0; wake = 1'b0;
    tick(3);
    check_eq("rst_t_phase", t_phase, 0);
    check_eq("rst_m_count", m_count, 0);
    check_eq("rst_outs", {t_rise, t_fall, m_en, halted, clk_err}, 0);
    rst = 1'b0;
    tick(2);

    // basic sequencing, 24-clk period
    snap();
    for (int i = 0; i < 8; i++) begin
      rise_cycle(12, 12);
      check_eq($sformatf("seq_phase_%0d", i), last_phase, (i + 1) % 4);
    end
    check_eq("seq_rises", rise_cnt - s_rise, 8);
    check_eq("seq_falls", fall_cnt - s_fall, 8);
    check_eq("seq_m_en", men_cnt - s_men, 2);
    check_eq("seq_m_count", m_count, 2);
    check_eq("seq_width_err", width_err, 0);

    // halt requested at t_phase 1
    rise_cycle(12, 12);
    check_eq("halt_p1", last_phase, 1);
    halt_req = 1'b1; tick(1); halt_req = 1'b0;
    check_eq("halt_pend_not_halted", halted, 0);
    rise_cycle(12, 12);
    rise_cycle(12, 12);
    check_eq("halt_p3", last_phase, 3);
    cpu_clk_in = 1'b1;
    tick(1);
    check_eq("halt_wrap_phase", t_phase, 0);
    check_eq("halt_wrap_m_en", m_en, 1);
    check_eq("halt_asserted", halted, 1);
    tick(11); cpu_clk_in = 1'b0; tick(12);
    check_eq("halt_m_count", m_count, 3);
    snap();
    for (int i = 0; i < 4; i++) begin
      rise_cycle(12, 12);
      check_eq($sformatf("halted_phase_%0d", i), last_phase, 0);
    end
    check_eq("halted_no_m_en", men_cnt - s_men, 0);
    check_eq("halted_rises", rise_cnt - s_rise, 4);
    check_eq("halted_still", halted, 1);
    check_eq("halted_m_count", m_count, 3);

    // wake from HALTED
    wake = 1'b1; tick(1); wake = 1'b0;
    check_eq("wake_halted_low", halted, 0);
    rise_cycle(12, 12);
    check_eq("wake_first_phase", last_phase, 1);
    rise_cycle(12, 12);
    rise_cycle(12, 12);
    rise_cycle(12, 12);
    check_eq("wake_wrap_phase", last_phase, 0);
    check_eq("wake_wrap_m_en", last_m_en, 1);
    check_eq("wake_m_count", m_count, 4);

    // simultaneous halt_req and wake: no halt
    halt_req = 1'b1; wake = 1'b1; tick(1); halt_req = 1'b0; wake = 1'b0;
    snap();
    for (int i = 0; i < 4; i++) begin
      rise_cycle(12, 12);
      check_eq($sformatf("both_phase_%0d", i), last_phase, (i + 1) % 4);
    end
    check_eq("both_never_halted", halted_cnt - s_halt, 0);
    check_eq("both_m_en", men_cnt - s_men, 1);
    check_eq("both_m_count", m_count, 5);

    // 4-bit m_count wrap, fast period
    for (int i = 0; i < 40; i++) rise_cycle(2, 2);
    check_eq("wrap_m_count_15", m_count, 15);
    for (int i = 0; i < 4; i++) rise_cycle(2, 2);
    check_eq("wrap_m_count_0", m_count, 0);
    check_eq("wrap_m_en", last_m_en, 1);
    for (int i = 0; i < 20; i++) rise_cycle(2, 2);
    check_eq("wrap_m_count_5", m_count, 5);

    // missing-edge watchdog
    tick(20);
    check_eq("wdog_early", clk_err, 0);
    tick(20);
    check_eq("wdog_gap40", clk_err, EXP_ERR);
    rise_cycle(12, 12);
    rise_cycle(12, 12);
    check_eq("wdog_sticky", clk_err, EXP_ERR);
    check_eq("wdog_phase", last_phase, 2);

    // async reset mid M-cycle with cpu_clk_in held high
    cpu_clk_in = 1'b1;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_phase", t_phase, 0);
    check_eq("mid_rst_m_count", m_count, 0);
    check_eq("mid_rst_err", clk_err, 0);
    tick(2);
    rst = 1'b0;
    tick(1);
    check_eq("post_rst_t_rise", t_rise, 1);
    check_eq("post_rst_phase", t_phase, 1);
    tick(1);
    check_eq("post_rst_t_rise_gone", t_rise, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
